// File: rtl/rv32i_wb_core.sv
// Multi-cycle RV32I core with Wishbone instruction/data masters and a lock-step debug port.
// Optional: define CORE_ILLEGAL_HALT_EN to halt on ECALL/EBREAK/unrecognised encodings.
module rv32i_wb_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       inst_adr_o,
  output logic              inst_cyc_o,
  output logic              inst_stb_o,
  input  logic [31:0]       inst_dat_i,
  input  logic              inst_ack_i,
  output logic [31:0]       data_adr_o,
  output logic [31:0]       data_dat_o,
  input  logic [31:0]       data_dat_i,
  output logic              data_we_o,
  output logic [3:0]        data_sel_o,
  output logic              data_cyc_o,
  output logic              data_stb_o,
  input  logic              data_ack_i,
  output logic [31:0][31:0] debug_registers,
  output logic [31:0]       pc_debug,
  output logic              pre_execution,
  output logic              post_execution,
  output logic              halted
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67,
                         OP_BR = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_IMM = 7'h13,
                         OP_OP = 7'h33, OP_FENCE = 7'h0F;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_POST, S_HALT} state_t;

  state_t             r_state;
  logic [31:0]        r_pc, r_inst, r_rs1v, r_rs2v, r_res, r_npc, r_ldata;
  logic [31:0][31:0]  r_regs;
  logic [1:0]         r_alo;
  logic               r_inst_cyc, r_data_cyc, r_data_we, r_pre, r_post;
  logic [3:0]         r_data_sel;
  logic [31:0]        r_data_dat, r_data_adr;
`ifdef CORE_ILLEGAL_HALT_EN
  logic               r_halted;
`endif

  logic [6:0]  w_opc, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2, w_sh;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_op_b, w_alu, w_ea, w_pc4, w_npc, w_res, w_sdat, w_ld;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [3:0]  w_sel;
  logic        w_legal, w_wr, w_wen, w_mem, w_alt, w_take, w_lt, w_ltu;

  assign w_opc = r_inst[6:0];
  assign w_rd  = r_inst[11:7];
  assign w_f3  = r_inst[14:12];
  assign w_rs1 = r_inst[19:15];
  assign w_rs2 = r_inst[24:20];
  assign w_f7  = r_inst[31:25];

  assign w_imm_i = {{20{r_inst[31]}}, r_inst[31:20]};
  assign w_imm_s = {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
  assign w_imm_b = {{19{r_inst[31]}}, r_inst[31], r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0};
  assign w_imm_u = {r_inst[31:12], 12'b0};
  assign w_imm_j = {{11{r_inst[31]}}, r_inst[31], r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0};

  // Legality doubles as the NOP/halt selector for everything outside the base ISA.
  always_comb begin
    w_legal = 1'b0;
    w_wr    = 1'b0;
    case (w_opc)
      OP_LUI, OP_AUIPC, OP_JAL: begin w_legal = 1'b1; w_wr = 1'b1; end
      OP_JALR:  begin w_legal = (w_f3 == 3'd0); w_wr = 1'b1; end
      OP_BR:    w_legal = (w_f3 != 3'd2) && (w_f3 != 3'd3);
      OP_LOAD:  begin w_legal = (w_f3 != 3'd3) && (w_f3 < 3'd6); w_wr = 1'b1; end
      OP_STORE: w_legal = (w_f3 < 3'd3);
      OP_IMM: begin
        w_wr = 1'b1;
        if (w_f3 == 3'd1)      w_legal = (w_f7 == 7'h00);
        else if (w_f3 == 3'd5) w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
        else                   w_legal = 1'b1;
      end
      OP_OP: begin
        w_wr    = 1'b1;
        w_legal = (w_f7 == 7'h00) || ((w_f7 == 7'h20) && ((w_f3 == 3'd0) || (w_f3 == 3'd5)));
      end
      OP_FENCE: w_legal = 1'b1;
      default:  w_legal = 1'b0;
    endcase
  end

  assign w_wen = w_legal && w_wr && (w_rd != 5'd0);
  assign w_mem = w_legal && ((w_opc == OP_LOAD) || (w_opc == OP_STORE));

  assign w_op_b = (w_opc == OP_OP) ? r_rs2v : w_imm_i;
  assign w_sh   = w_op_b[4:0];
  assign w_alt  = ((w_opc == OP_OP) || (w_f3 == 3'd5)) && w_f7[5];

  always_comb begin
    case (w_f3)
      3'd0:    w_alu = w_alt ? r_rs1v - w_op_b : r_rs1v + w_op_b;
      3'd1:    w_alu = r_rs1v << w_sh;
      3'd2:    w_alu = {31'b0, $signed(r_rs1v) < $signed(w_op_b)};
      3'd3:    w_alu = {31'b0, r_rs1v < w_op_b};
      3'd4:    w_alu = r_rs1v ^ w_op_b;
      3'd5:    w_alu = w_alt ? 32'($signed(r_rs1v) >>> w_sh) : r_rs1v >> w_sh;
      3'd6:    w_alu = r_rs1v | w_op_b;
      default: w_alu = r_rs1v & w_op_b;
    endcase
  end

  assign w_lt  = $signed(r_rs1v) < $signed(r_rs2v);
  assign w_ltu = r_rs1v < r_rs2v;

  always_comb begin
    case (w_f3)
      3'd0:    w_take = (r_rs1v == r_rs2v);
      3'd1:    w_take = (r_rs1v != r_rs2v);
      3'd4:    w_take = w_lt;
      3'd5:    w_take = !w_lt;
      3'd6:    w_take = w_ltu;
      3'd7:    w_take = !w_ltu;
      default: w_take = 1'b0;
    endcase
  end

  assign w_ea  = r_rs1v + ((w_opc == OP_STORE) ? w_imm_s : w_imm_i);
  assign w_pc4 = r_pc + 32'd4;

  always_comb begin
    w_npc = w_pc4;
    w_res = w_alu;
    case (w_opc)
      OP_LUI:   w_res = w_imm_u;
      OP_AUIPC: w_res = r_pc + w_imm_u;
      OP_JAL:   begin w_res = w_pc4; w_npc = r_pc + w_imm_j; end
      OP_JALR:  begin w_res = w_pc4; if (w_legal) w_npc = {w_ea[31:1], 1'b0}; end
      OP_BR:    if (w_legal && w_take) w_npc = r_pc + w_imm_b;
      default:  ;
    endcase
  end

  // Misaligned half/word accesses just drop the low address bits.
  always_comb begin
    case (w_f3[1:0])
      2'd0:    begin w_sel = 4'b0001 << w_ea[1:0]; w_sdat = {4{r_rs2v[7:0]}}; end
      2'd1:    begin w_sel = w_ea[1] ? 4'b1100 : 4'b0011; w_sdat = {2{r_rs2v[15:0]}}; end
      default: begin w_sel = 4'b1111; w_sdat = r_rs2v; end
    endcase
  end

  assign w_byte = r_ldata[{r_alo, 3'b000} +: 8];
  assign w_half = r_alo[1] ? r_ldata[31:16] : r_ldata[15:0];

  always_comb begin
    case (w_f3)
      3'd0:    w_ld = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_ld = {{16{w_half[15]}}, w_half};
      3'd4:    w_ld = {24'b0, w_byte};
      3'd5:    w_ld = {16'b0, w_half};
      default: w_ld = r_ldata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_regs     <= '0;
      r_inst     <= '0;
      r_rs1v     <= '0;
      r_rs2v     <= '0;
      r_res      <= '0;
      r_npc      <= '0;
      r_ldata    <= '0;
      r_alo      <= '0;
      r_inst_cyc <= 1'b0;
      r_data_cyc <= 1'b0;
      r_data_we  <= 1'b0;
      r_data_sel <= '0;
      r_data_dat <= '0;
      r_data_adr <= '0;
      r_pre      <= 1'b0;
      r_post     <= 1'b0;
`ifdef CORE_ILLEGAL_HALT_EN
      r_halted   <= 1'b0;
`endif
    end else begin
      r_pre  <= 1'b0;
      r_post <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_inst_cyc <= 1'b1;
          if (r_inst_cyc && inst_ack_i) begin
            r_inst     <= inst_dat_i;
            r_inst_cyc <= 1'b0;
            r_pre      <= 1'b1;
            r_state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_rs1v  <= r_regs[w_rs1];
          r_rs2v  <= r_regs[w_rs2];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_res <= w_res;
          r_npc <= w_npc;
          r_alo <= w_ea[1:0];
`ifdef CORE_ILLEGAL_HALT_EN
          if (!w_legal) begin
            r_post  <= 1'b1;
            r_state <= S_POST;
          end else
`endif
          if (w_mem) begin
            r_data_cyc <= 1'b1;
            r_data_we  <= (w_opc == OP_STORE);
            r_data_sel <= w_sel;
            r_data_dat <= w_sdat;
            r_data_adr <= {w_ea[31:2], 2'b00};
            r_state    <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (data_ack_i) begin
            if (!r_data_we) r_ldata <= data_dat_i;
            r_data_cyc <= 1'b0;
            r_data_we  <= 1'b0;
            r_data_sel <= '0;
            r_state    <= S_WB;
          end
        end
        S_WB: begin
          if (w_wen) r_regs[w_rd] <= (w_opc == OP_LOAD) ? w_ld : r_res;
          r_pc    <= r_npc;
          r_post  <= 1'b1;
          r_state <= S_POST;
        end
        S_POST: begin
`ifdef CORE_ILLEGAL_HALT_EN
          if (!w_legal) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_inst_cyc <= 1'b1;
            r_state    <= S_FETCH;
          end
`else
          r_inst_cyc <= 1'b1;
          r_state    <= S_FETCH;
`endif
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign inst_adr_o      = r_pc;
  assign inst_cyc_o      = r_inst_cyc;
  assign inst_stb_o      = r_inst_cyc;
  assign data_adr_o      = r_data_adr;
  assign data_dat_o      = r_data_dat;
  assign data_we_o       = r_data_we;
  assign data_sel_o      = r_data_sel;
  assign data_cyc_o      = r_data_cyc;
  assign data_stb_o      = r_data_cyc;
  assign debug_registers = r_regs;
  assign pc_debug        = r_pc;
  assign pre_execution   = r_pre;
  assign post_execution  = r_post;
`ifdef CORE_ILLEGAL_HALT_EN
  assign halted = r_halted;
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_rv32i_wb_core.sv
// Self-checking bench: program table drives a retire scoreboard, with and without bus wait states.
module tb_rv32i_wb_core;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]       inst_adr_o, inst_dat_i, data_adr_o, data_dat_o, data_dat_i, pc_debug;
  logic              inst_cyc_o, inst_stb_o, inst_ack_i, data_we_o, data_cyc_o, data_stb_o, data_ack_i;
  logic [3:0]        data_sel_o;
  logic [31:0][31:0] debug_registers;
  logic              pre_execution, post_execution, halted;

  rv32i_wb_core #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .inst_adr_o(inst_adr_o), .inst_cyc_o(inst_cyc_o), .inst_stb_o(inst_stb_o),
    .inst_dat_i(inst_dat_i), .inst_ack_i(inst_ack_i),
    .data_adr_o(data_adr_o), .data_dat_o(data_dat_o), .data_dat_i(data_dat_i),
    .data_we_o(data_we_o), .data_sel_o(data_sel_o), .data_cyc_o(data_cyc_o),
    .data_stb_o(data_stb_o), .data_ack_i(data_ack_i),
    .debug_registers(debug_registers), .pc_debug(pc_debug),
    .pre_execution(pre_execution), .post_execution(post_execution), .halted(halted)
  );

  typedef struct packed {
    logic [31:0] pc, inst, npc;
    logic        chk_rd;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        mem, st;
    logic [3:0]  sel;
    logic [31:0] sadr, sdat;
  } rec_t;

  int checks = 0, failures = 0;
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
  int pre_cnt = 0, cyc_cnt = 0;
  logic lat_on = 1'b0, have_prev = 1'b0, st_seen = 1'b0;
  logic [31:0] imem [64];
  logic [31:0] dmem [256];
  rec_t prog [27];
  rec_t sb_q [$];
  rec_t r;

  // Slave models: combinational ack after a programmable number of wait cycles.
  assign inst_ack_i = inst_cyc_o && inst_stb_o && (icnt >= iwait);
  assign inst_dat_i = imem[inst_adr_o[7:2]];
  assign data_ack_i = data_cyc_o && data_stb_o && (dcnt >= dwait);
  assign data_dat_i = dmem[data_adr_o[9:2]];

  always @(posedge clk) begin
    if (!rst) begin
      icnt <= 0;
      dcnt <= 0;
      for (int i = 0; i < 256; i++) dmem[i] <= 32'h0;
    end else begin
      icnt <= (inst_cyc_o && inst_stb_o && !inst_ack_i) ? icnt + 1 : 0;
      dcnt <= (data_cyc_o && data_stb_o && !data_ack_i) ? dcnt + 1 : 0;
      if (data_cyc_o && data_stb_o && data_we_o && data_ack_i)
        for (int b = 0; b < 4; b++)
          if (data_sel_o[b]) dmem[data_adr_o[9:2]][8*b +: 8] <= data_dat_o[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    logic [31:0] acc;
    acc = 32'h0;
    for (int i = 0; i < 32; i++) acc = acc | debug_registers[i];
    chk({nm, "_bus"}, {19'b0, inst_cyc_o, inst_stb_o, data_cyc_o, data_stb_o, data_we_o,
                       data_sel_o, pre_execution, post_execution, halted}, 32'h0);
    chk({nm, "_pc"}, pc_debug, 32'h0);
    chk({nm, "_regs"}, acc, 32'h0);
  endtask

  function automatic logic [31:0] ei(input logic [11:0] imm, input logic [4:0] rs1,
                                     input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] es(input logic [11:0] imm, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(input logic [12:0] imm, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] eu(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] ej(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] er(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic rec_t ra(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] npc,
                              input logic c, input logic [4:0] rd, input logic [31:0] val);
    rec_t x;
    x = '0;
    x.pc = pc; x.inst = inst; x.npc = npc; x.chk_rd = c; x.rd = rd; x.val = val;
    return x;
  endfunction
  function automatic rec_t rl(input logic [31:0] pc, input logic [31:0] inst,
                              input logic [4:0] rd, input logic [31:0] val);
    rec_t x;
    x = ra(pc, inst, pc + 32'd4, 1'b1, rd, val);
    x.mem = 1'b1;
    return x;
  endfunction
  function automatic rec_t rs(input logic [31:0] pc, input logic [31:0] inst, input logic [3:0] sel,
                              input logic [31:0] adr, input logic [31:0] dat);
    rec_t x;
    x = ra(pc, inst, pc + 32'd4, 1'b0, 5'd0, 32'h0);
    x.mem = 1'b1; x.st = 1'b1; x.sel = sel; x.sadr = adr; x.sdat = dat;
    return x;
  endfunction

  // Retire monitor: pre checks the fetched PC, post pops and checks architectural state.
  always @(negedge clk) begin
    if (!rst) begin
      pre_cnt = 0; cyc_cnt = 0; have_prev = 1'b0; st_seen = 1'b0;
    end else begin
      cyc_cnt++;
      if (pre_execution && post_execution) chk("pre_post_overlap", 32'd1, 32'd0);
      if (sb_q.size() != 0) begin
        if (data_cyc_o && data_stb_o && data_we_o && !st_seen) begin
          st_seen = 1'b1;
          chk("store_expected", {31'b0, sb_q[0].st}, 32'd1);
          chk("store_sel", {28'b0, data_sel_o}, {28'b0, sb_q[0].sel});
          chk("store_adr", data_adr_o, sb_q[0].sadr);
          chk("store_dat", data_dat_o, sb_q[0].sdat);
        end
        if (pre_execution) begin
          pre_cnt++;
          chk("pre_pc", pc_debug, sb_q[0].pc);
        end
        if (post_execution) begin
          r = sb_q.pop_front();
          chk("pre_count", pre_cnt, 32'd1);
          chk("post_pc", pc_debug, r.npc);
          if (r.chk_rd) chk($sformatf("x%0d@%0h", r.rd, r.pc), debug_registers[r.rd], r.val);
          chk("x0", debug_registers[0], 32'h0);
          if (lat_on && have_prev) chk("latency", cyc_cnt, r.mem ? 32'd6 : 32'd5);
          pre_cnt = 0; cyc_cnt = 0; have_prev = 1'b1; st_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    prog[0]  = ra(32'h00, ei(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 32'h04, 1'b1, 5'd1, 32'h0000_0005);
    prog[1]  = ra(32'h04, eu(20'h12345, 5'd3, 7'h37), 32'h08, 1'b1, 5'd3, 32'h1234_5000);
    prog[2]  = ra(32'h08, eu(20'h00001, 5'd4, 7'h17), 32'h0C, 1'b1, 5'd4, 32'h0000_1008);
    prog[3]  = ra(32'h0C, ei(12'hFF9, 5'd1, 3'd0, 5'd2, 7'h13), 32'h10, 1'b1, 5'd2, 32'hFFFF_FFFE);
    prog[4]  = ra(32'h10, ei(12'd1, 5'd0, 3'd0, 5'd0, 7'h13), 32'h14, 1'b1, 5'd0, 32'h0);
    prog[5]  = ra(32'h14, ei(12'h080, 5'd0, 3'd0, 5'd5, 7'h13), 32'h18, 1'b1, 5'd5, 32'h0000_0080);
    prog[6]  = rs(32'h18, es(12'h101, 5'd5, 5'd0, 3'd0), 4'b0010, 32'h100, 32'h8080_8080);
    prog[7]  = rl(32'h1C, ei(12'h101, 5'd0, 3'd0, 5'd6, 7'h03), 5'd6, 32'hFFFF_FF80);
    prog[8]  = ra(32'h20, eb(13'd16, 5'd0, 5'd0, 3'd0), 32'h30, 1'b0, 5'd0, 32'h0);
    prog[9]  = rl(32'h30, ei(12'h101, 5'd0, 3'd4, 5'd7, 7'h03), 5'd7, 32'h0000_0080);
    prog[10] = ra(32'h34, ej(21'd12, 5'd0), 32'h40, 1'b0, 5'd0, 32'h0);
    prog[11] = ra(32'h40, ej(21'd8, 5'd1), 32'h48, 1'b1, 5'd1, 32'h0000_0044);
    prog[12] = ra(32'h48, ei(12'hFF0, 5'd0, 3'd0, 5'd8, 7'h13), 32'h4C, 1'b1, 5'd8, 32'hFFFF_FFF0);
    prog[13] = ra(32'h4C, ei(12'h402, 5'd8, 3'd5, 5'd9, 7'h13), 32'h50, 1'b1, 5'd9, 32'hFFFF_FFFC);
    prog[14] = ra(32'h50, ei(12'd28, 5'd8, 3'd5, 5'd10, 7'h13), 32'h54, 1'b1, 5'd10, 32'h0000_000F);
    prog[15] = ra(32'h54, er(7'h00, 5'd1, 5'd8, 3'd2, 5'd11), 32'h58, 1'b1, 5'd11, 32'h1);
    prog[16] = ra(32'h58, er(7'h00, 5'd1, 5'd8, 3'd3, 5'd12), 32'h5C, 1'b1, 5'd12, 32'h0);
    prog[17] = ra(32'h5C, er(7'h20, 5'd8, 5'd1, 3'd0, 5'd13), 32'h60, 1'b1, 5'd13, 32'h0000_0054);
    prog[18] = rs(32'h60, es(12'h200, 5'd3, 5'd0, 3'd2), 4'b1111, 32'h200, 32'h1234_5000);
    prog[19] = rl(32'h64, ei(12'h200, 5'd0, 3'd2, 5'd14, 7'h03), 5'd14, 32'h1234_5000);
    prog[20] = rs(32'h68, es(12'h202, 5'd2, 5'd0, 3'd1), 4'b1100, 32'h200, 32'hFFFE_FFFE);
    prog[21] = rl(32'h6C, ei(12'h202, 5'd0, 3'd5, 5'd15, 7'h03), 5'd15, 32'h0000_FFFE);
    prog[22] = rl(32'h70, ei(12'h200, 5'd0, 3'd1, 5'd16, 7'h03), 5'd16, 32'h0000_5000);
    prog[23] = ra(32'h74, eb(13'd8, 5'd1, 5'd1, 3'd1), 32'h78, 1'b0, 5'd0, 32'h0);
    prog[24] = ra(32'h78, ei(12'h041, 5'd1, 3'd0, 5'd17, 7'h67), 32'h84, 1'b1, 5'd17, 32'h0000_007C);
    prog[25] = ra(32'h84, 32'h0000_000F, 32'h88, 1'b0, 5'd0, 32'h0);
    prog[26] = ra(32'h88, 32'h0000_0073, 32'h8C, 1'b0, 5'd0, 32'h0);

    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_006F;
    for (int k = 0; k < 27; k++) imem[prog[k].pc[7:2]] = prog[k].inst;

    for (int p = 0; p < 2; p++) begin
      rst = 1'b0;
      iwait = (p == 0) ? 0 : 3;
      dwait = iwait;
      lat_on = (p == 0);
      repeat (3) @(negedge clk);
      chk_reset((p == 0) ? "reset0" : "reset1");
      for (int k = 0; k < 27; k++) sb_q.push_back(prog[k]);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 20 && !inst_cyc_o; c++) @(negedge clk);
      chk("first_fetch_cyc", {31'b0, inst_cyc_o}, 32'd1);
      chk("first_fetch_adr", inst_adr_o, 32'h0);
      for (int c = 0; c < 4000 && sb_q.size() != 0; c++) @(negedge clk);
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      sb_q.delete();
    end

    // Reset landing in the middle of a data bus cycle.
    rst = 1'b0;
    iwait = 2;
    dwait = 2;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 500 && !data_cyc_o; c++) @(negedge clk);
    chk("midop_data_cyc_seen", {31'b0, data_cyc_o}, 32'd1);
    chk("midop_x5_before", debug_registers[5], 32'h0000_0080);
    rst = 1'b0;
    #1;
    chk_reset("reset_midop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
